// File: rtl/vec_pkg.sv
// Shared types and sizes for the vector memory sequencer.
package vec_pkg;

  localparam int LANES = 8;
  localparam int NREGS = 16;
  localparam int VEC_N = 20;

  typedef logic [LANES-1:0][VEC_N-1:0] vec_t;

  typedef enum logic {
    VLOAD  = 1'b0,
    VSTORE = 1'b1
  } vmem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    FIN
  } vmem_state_e;

endpackage

// File: rtl/vec_addr_gen.sv
// Lane address generator: walks base, base+stride, base+2*stride, ...
// using an accumulator rather than a multiplier. Wraps silently mod 2^AW.
module vec_addr_gen #(
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_stride,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_stride;

  // Capture base/stride on acceptance, then advance one stride per lane.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr   <= '0;
      r_stride <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/vec_mem_unit.sv
// Vector load/store sequencer between the vector register file and the
// word-wide data memory. Loads gather 8 words and commit them in one
// register file write; stores scatter 8 latched lanes, one word per cycle.
module vec_mem_unit
  import vec_pkg::*;
#(
  parameter int N  = 20,
  parameter int AW = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_op,
  input  logic [AW-1:0]            i_base,
  input  logic [AW-1:0]            i_stride,
  input  logic [$clog2(NREGS)-1:0] i_vd,
  input  logic [LANES-1:0][N-1:0]  i_vs_data,
  output logic [AW-1:0]            o_mem_addr,
  output logic                     o_mem_we,
  output logic [N-1:0]             o_mem_wd,
  input  logic [N-1:0]             i_mem_rd,
  output logic                     o_rf_we,
  output logic [$clog2(NREGS)-1:0] o_rf_wa,
  output logic [LANES-1:0][N-1:0]  o_rf_wd,
  output logic                     o_busy,
  output logic                     o_done
);

  vmem_state_e                r_state;
  vmem_state_e                w_nextState;
  logic [3:0]                 r_k;
  vmem_op_e                   r_op;
  logic [$clog2(NREGS)-1:0]   r_vd;
  logic [LANES-1:0][N-1:0]    r_src;
  logic [LANES-1:0][N-1:0]    r_asm;
  logic                       w_accept;
  logic                       w_step;
  logic [2:0]                 w_capLane;

  // Read data arrives one cycle after its address, so lane k-1 lands in cycle k.
  assign w_capLane = 3'(r_k - 4'd1);

  vec_addr_gen #(
    .AW(AW)
  ) u_addrGen (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_base   (i_base),
    .i_stride (i_stride),
    .o_addr   (o_mem_addr)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and strobes; write enables are also masked by reset so an
  // abort never lets one more word or vector slip into storage.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_rf_we     = 1'b0;
    o_mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_accept    = 1'b1;
          w_nextState = i_op ? STORE : LOAD;
        end
      end
      LOAD: begin
        w_step = (r_k < 4'd7);
        if (r_k == 4'd8) begin
          w_nextState = FIN;
        end
      end
      STORE: begin
        o_mem_we = ~i_reset;
        w_step   = (r_k < 4'd7);
        if (r_k == 4'd7) begin
          w_nextState = FIN;
        end
      end
      FIN: begin
        o_done      = 1'b1;
        o_rf_we     = (r_op == VLOAD) & ~i_reset;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request latching, lane counting, load assembly and store lane shifting.
  // The store source shifts down so lane k always sits in slot 0, and stops
  // on the last lane so the write data holds afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_k   <= '0;
      r_op  <= VLOAD;
      r_vd  <= '0;
      r_src <= '0;
      r_asm <= '0;
    end else if (w_accept) begin
      r_k  <= '0;
      r_op <= vmem_op_e'(i_op);
      r_vd <= i_vd;
      if (i_op) begin
        r_src <= i_vs_data;
      end
    end else if (r_state == LOAD || r_state == STORE) begin
      r_k <= r_k + 4'd1;
      if (r_state == LOAD && r_k != 4'd0) begin
        r_asm[w_capLane] <= i_mem_rd;
      end
      if (r_state == STORE && w_step) begin
        r_src <= r_src >> N;
      end
    end
  end

  assign o_mem_wd = r_src[0];
  assign o_rf_wa  = r_vd;
  assign o_rf_wd  = r_asm;

endmodule

// File: doc/vec_mem_unit.md
# vec_mem_unit

Vector load/store sequencer between the vector register file and the scalar-width data memory. It is the producer for the register file write port (we3/ra3/wd3) and the consumer of one register file read port. A vector load gathers 8 N-bit memory words into one 8-lane vector and commits it in a single write cycle. A vector store scatters the 8 lanes of a latched source vector to memory, one word per cycle.

## Interface
- N, 20, lane width in bits; equals memory data width
- AW, 32, memory address width
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- start  in  1  request strobe; sampled only in IDLE
- op  in  1  0 = load, 1 = store
- base  in  AW  address of lane 0
- stride  in  AW  address increment between lanes, in words
- vd  in  4  destination register for a load
- vs_data  in  8×N  source vector for a store (register file rd port)
- mem_addr  out  AW  memory word address
- mem_we  out  1  memory write enable
- mem_wd  out  N  memory write data
- mem_rd  in  N  memory read data, valid one cycle after mem_addr
- rf_we  out  1  register file write enable (drives we3)
- rf_wa  out  4  register file write address (drives ra3)
- rf_wd  out  8×N  register file write data (drives wd3)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, STORE, FIN.
- IDLE: when start=1, latch op, base, stride, vd, and vs_data (stores only). Clear lane counter k. Go to LOAD or STORE.
- LOAD: runs 9 cycles, k=0..8.
  - For k≤7: mem_addr = base + k·stride, mem_we=0.
  - For k≥1: capture mem_rd into lane k-1 of the assembly buffer.
  - After k=8, go to FIN.
- STORE: runs 8 cycles, k=0..7.
  - mem_addr = base + k·stride, mem_we=1, mem_wd = latched lane k.
  - After k=7, go to FIN.
- FIN: one cycle. done=1. For a load only: rf_we=1, rf_wa=latched vd, rf_wd=assembly buffer. Then go to IDLE.
- Address arithmetic is modulo 2^AW; wrap-around is silent. The k·stride product is truncated to AW bits. stride=0 repeats one address.
- Lane order: lane 0 is the lowest address and occupies rf_wd bits [N-1:0].
- start while busy: ignored, no queueing.
- vs_data is sampled only at acceptance. Later changes on the read port have no effect.
- Outside the cases above: mem_we=0, rf_we=0, done=0. mem_addr, mem_wd, and rf_wd hold their last value (don't-care).

## Timing
- Reset: state=IDLE, k=0, busy=0, done=0, rf_we=0, mem_we=0, mem_addr=0, mem_wd=0, rf_wa=0, rf_wd=0, assembly buffer=0.
- Reset mid-operation: abort on the next edge. No rf write, no further mem writes. Memory words already written stay written. Partial vector is discarded.
- start accepted at edge E0. First mem access is in the cycle after E0.
- Load: rf_we is high in cycle 10 after E0 (9 LOAD + 1 FIN). busy is high for 10 cycles.
- Store: done is high in cycle 9 after E0. busy is high for 9 cycles.
- The earliest next start is accepted in the cycle after FIN.
- rf_we is a posedge-registered level held for a full cycle. The register file commits on the following negedge.
- Load-after-store to the same addresses: the store completes before the load is accepted, so the load returns the stored data.

## Structure
- Shared package vec_pkg:
  - LANES=8, NREGS=16
  - typedef vec_t = logic [LANES-1:0][N-1:0] (N passed as parameter to users)
  - enum vmem_op_e {VLOAD, VSTORE}
  - enum vmem_state_e {IDLE, LOAD, STORE, FIN}
- One sub-module, vec_addr_gen: registered base/stride, produces base + k·stride. Implemented as an accumulator (addr += stride each lane), not a multiplier.

## Test plan
- Load, base=0x100, stride=1, mem[0x100+i]=i+1 → single rf_we pulse in cycle 10, rf_wa=vd=5, lane i = i+1, done coincident with rf_we.
- Store, base=0x40, stride=2, vs_data lane i = 0xA0+i → mem_we high for 8 cycles at addresses 0x40,0x42,…,0x4E with data 0xA0…0xA7, rf_we never high, done in cycle 9.
- Wrap: base=0xFFFFFFFE, stride=1, load → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0…0x5, correct lane order.
- start pulsed during LOAD at k=3 → ignored, exactly one rf write, busy continuous.
- reset asserted at STORE k=4 → mem_we=0 from the next cycle, only lanes 0–3 written, all outputs at reset values, a new start is accepted normally.
- Back-to-back store then load of the same region, with vs_data changed right after acceptance → memory holds the originally sampled vector, load returns it into vd.
